led_stream_decoder: RTL and testbench
=====================================

LED_STREAM_DECODER -- requirements
Module: led_stream_decoder

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 150, meaning maximum pixels accepted per frame.
REQ-002 SHALL have parameter T_ONE_MIN, default 8, meaning minimum high width in clocks decoded as bit 1.
REQ-003 SHALL have parameter T_HIGH_MIN, default 2, meaning minimum valid high width in clocks.
REQ-004 SHALL have parameter T_HIGH_MAX, default 16, meaning maximum valid high width in clocks.
REQ-005 SHALL have parameter T_LATCH, default 600, meaning low width in clocks (50 us) that ends a frame.
REQ-006 SHALL have port clock_12mhz  input  1  system clock, 12 MHz.
REQ-007 SHALL have port led_counter_reset  input  1  reset, asynchronous, active-high.
REQ-008 SHALL have port din  input  1  asynchronous WS2812-format serial LED data.
REQ-009 SHALL have port pixel_data  output  24  last decoded pixel, GRB, MSB first received in bit 23.
REQ-010 SHALL have port pixel_valid  output  1  one-clock pulse, pixel_data/pixel_index valid.
REQ-011 SHALL have port pixel_index  output  8  position of pixel_data in frame, first pixel 0.
REQ-012 SHALL have port frame_done  output  1  one-clock pulse on latch detection after at least one pixel.
REQ-013 SHALL have port pixel_count  output  8  pixels accepted in the finished frame, valid with frame_done.
REQ-014 SHALL have port bit_error  output  1  one-clock pulse on any timing or framing violation.
REQ-015 SHALL have port overflow  output  1  sticky, set when a frame delivers more than NUM_LEDS pixels.

Function
REQ-016 SHALL pass din through a two-flop synchronizer; all timing counts refer to the synchronized signal.
REQ-017 SHALL implement states SYNC, IDLE, HIGH, LOW.
REQ-018 SHALL enter SYNC on reset; leave to IDLE only after T_LATCH consecutive low clocks; ignore all pulses before that.
REQ-019 SHALL in IDLE and LOW go to HIGH on a rising edge, clearing the high-width counter to 1.
REQ-020 SHALL in HIGH count clocks (5-bit, saturating at 31); on falling edge decode width w: T_HIGH_MIN<=w<T_ONE_MIN -> 0, T_ONE_MIN<=w<=T_HIGH_MAX -> 1, else bit_error and go to SYNC.
REQ-021 SHALL shift the decoded bit into a 24-bit register MSB first and increment a 5-bit bit counter, then go to LOW.
REQ-022 SHALL on the 24th bit present the register on pixel_data with pixel_valid high the clock after the falling edge is seen, clear the bit counter, increment pixel_index.
REQ-023 SHALL in LOW count low clocks (10-bit, saturating); at T_LATCH go to IDLE and perform latch handling.
REQ-024 SHALL on latch with bit counter nonzero pulse bit_error and discard the partial pixel.
REQ-025 SHALL on latch with at least one pixel pulse frame_done with pixel_count, then clear pixel_index and pixel_count.
REQ-026 SHALL suppress pixel_valid for pixels beyond NUM_LEDS, set overflow, keep pixel_count at NUM_LEDS.
REQ-027 SHALL hold pixel_data between pulses; pixel_valid and frame_done never in the same clock.
REQ-028 SHALL treat din high for more than T_HIGH_MAX clocks as bit_error immediately at T_HIGH_MAX+1, then SYNC.

Reset
REQ-029 SHALL on led_counter_reset asynchronously set state SYNC, pixel_data 0, pixel_index 0, pixel_count 0, all pulses 0, overflow 0, counters and synchronizer 0.
REQ-030 SHALL on reset mid-pixel discard all partial data without pulsing bit_error or frame_done.

Structure
REQ-031 SHALL take NUM_LEDS and timing defaults from the shared led_protocol_pkg used by the transmit side.
REQ-032 SHALL place synchronizer and rising/falling edge detection in sub-module led_input_sync.

Verification
REQ-033 Reset, 600 low, 24 bits of 0xFF0000 (10 high/5 low for 1, 5 high/10 low for 0), 600 low -> pixel_valid once, pixel_data 0xFF0000, pixel_index 0, frame_done with pixel_count 1.
REQ-034 Full frame 150 pixels alternating 0x00AA55/0x55AA00 then latch -> 150 pixel_valid, indices 0..149, pixel_count 150, overflow 0.
REQ-035 151 pixels then latch -> 150 pixel_valid, overflow 1, pixel_count 150.
REQ-036 12 bits then 600 low -> bit_error one pulse, no pixel_valid, no frame_done.
REQ-037 High pulse of 20 clocks mid-pixel -> bit_error at clock 17 of high, pixels ignored until 600 low seen.
REQ-038 Pulses before initial latch gap, and reset asserted at bit 13 -> no outputs; next clean pixel decodes correctly.

Source files
------------

// File: rtl/led_protocol_pkg.sv
// Protocol constants shared by the WS2812-style LED transmit and receive blocks.
// Timing values are in 12 MHz clock cycles.
package led_protocol_pkg;
  localparam int unsigned NUM_LEDS_DEF   = 150;
  localparam int unsigned T_ONE_MIN_DEF  = 8;
  localparam int unsigned T_HIGH_MIN_DEF = 2;
  localparam int unsigned T_HIGH_MAX_DEF = 16;
  localparam int unsigned T_LATCH_DEF    = 600;
  localparam int unsigned PIXEL_BITS     = 24;

  typedef enum logic [1:0] {
    ST_SYNC,
    ST_IDLE,
    ST_HIGH,
    ST_LOW
  } dec_state_e;
endpackage

// File: rtl/led_input_sync.sv
// Two-flop synchronizer for the serial LED input, plus edge detection on the
// synchronized level.
module led_input_sync (
  input  logic clock_12mhz,
  input  logic led_counter_reset,
  input  logic din,
  output logic din_s_o,
  output logic rise_o,
  output logic fall_o
);
  // [1:0] are the synchronizer stages; [2] is the previous synchronized level.
  logic [2:0] sync_q;

  always_ff @(posedge clock_12mhz or posedge led_counter_reset) begin
    if (led_counter_reset) sync_q <= '0;
    else                   sync_q <= {sync_q[1:0], din};
  end

  assign din_s_o = sync_q[1];
  assign rise_o  = sync_q[1] & ~sync_q[2];
  assign fall_o  = ~sync_q[1] & sync_q[2];
endmodule

// File: rtl/led_stream_decoder.sv
// WS2812-format serial decoder: measures high-pulse widths to recover bits,
// assembles 24-bit GRB pixels and detects the latch gap that ends a frame.
//
// state | meaning
// SYNC  | waiting for T_LATCH consecutive low clocks before trusting the line
// IDLE  | frame boundary seen, waiting for the first rising edge
// HIGH  | measuring the width of a high pulse
// LOW   | between bits, timing the low gap for a latch
module led_stream_decoder
  import led_protocol_pkg::*;
#(
  parameter int unsigned NUM_LEDS   = NUM_LEDS_DEF,
  parameter int unsigned T_ONE_MIN  = T_ONE_MIN_DEF,
  parameter int unsigned T_HIGH_MIN = T_HIGH_MIN_DEF,
  parameter int unsigned T_HIGH_MAX = T_HIGH_MAX_DEF,
  parameter int unsigned T_LATCH    = T_LATCH_DEF
) (
  input  logic        clock_12mhz,
  input  logic        led_counter_reset,
  input  logic        din,
  output logic [23:0] pixel_data,
  output logic        pixel_valid,
  output logic [7:0]  pixel_index,
  output logic        frame_done,
  output logic [7:0]  pixel_count,
  output logic        bit_error,
  output logic        overflow
);
  localparam logic [4:0] HI_MIN   = 5'(T_HIGH_MIN);
  localparam logic [4:0] HI_MAX   = 5'(T_HIGH_MAX);
  localparam logic [4:0] ONE_MIN  = 5'(T_ONE_MIN);
  localparam logic [4:0] LAST_BIT = 5'(PIXEL_BITS - 1);
  localparam logic [9:0] LATCH_M1 = 10'(T_LATCH - 1);
  localparam logic [7:0] NUM_PIX  = 8'(NUM_LEDS);

  logic din_s, rise, fall;

  led_input_sync u_sync (
    .clock_12mhz      (clock_12mhz),
    .led_counter_reset(led_counter_reset),
    .din              (din),
    .din_s_o          (din_s),
    .rise_o           (rise),
    .fall_o           (fall)
  );

  dec_state_e  state_q, state_d;
  logic [4:0]  hi_cnt_q, hi_cnt_d;
  logic [9:0]  low_cnt_q, low_cnt_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [23:0] shift_q, shift_d;
  logic [7:0]  pix_cnt_q, pix_cnt_d;
  logic [23:0] pixel_data_q, pixel_data_d;
  logic [7:0]  pixel_index_q, pixel_index_d;
  logic [7:0]  pixel_count_q, pixel_count_d;
  logic        pixel_valid_q, pixel_valid_d;
  logic        frame_done_q, frame_done_d;
  logic        bit_error_q, bit_error_d;
  logic        overflow_q, overflow_d;
  logic        bit_val;
  logic [23:0] shift_next;

  always_comb begin
    state_d       = state_q;
    hi_cnt_d      = hi_cnt_q;
    low_cnt_d     = low_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    pix_cnt_d     = pix_cnt_q;
    pixel_data_d  = pixel_data_q;
    pixel_index_d = pixel_index_q;
    pixel_count_d = pixel_count_q;
    pixel_valid_d = 1'b0;
    frame_done_d  = 1'b0;
    bit_error_d   = 1'b0;
    overflow_d    = overflow_q;
    bit_val       = (hi_cnt_q >= ONE_MIN);
    shift_next    = {shift_q[22:0], bit_val};

    unique case (state_q)
      ST_SYNC: begin
        if (din_s) begin
          low_cnt_d = '0;
        end else if (low_cnt_q == LATCH_M1) begin
          state_d   = ST_IDLE;
          low_cnt_d = '0;
        end else begin
          low_cnt_d = low_cnt_q + 10'd1;
        end
      end
      ST_IDLE: begin
        if (rise) begin
          state_d  = ST_HIGH;
          hi_cnt_d = 5'd1;
        end
      end
      ST_HIGH: begin
        // A runt or over-long pulse aborts the frame; the line must go quiet
        // for a full latch gap before decoding resumes.
        if ((fall && hi_cnt_q < HI_MIN) || (!fall && hi_cnt_q == HI_MAX)) begin
          state_d       = ST_SYNC;
          bit_error_d   = 1'b1;
          bit_cnt_d     = '0;
          pix_cnt_d     = '0;
          pixel_index_d = '0;
          low_cnt_d     = '0;
        end else if (fall) begin
          state_d   = ST_LOW;
          low_cnt_d = 10'd1;
          shift_d   = shift_next;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            if (pix_cnt_q < NUM_PIX) begin
              pixel_valid_d = 1'b1;
              pixel_data_d  = shift_next;
              pixel_index_d = pix_cnt_q;
              pix_cnt_d     = pix_cnt_q + 8'd1;
            end else begin
              overflow_d = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end else if (hi_cnt_q != 5'd31) begin
          hi_cnt_d = hi_cnt_q + 5'd1;
        end
      end
      ST_LOW: begin
        if (rise) begin
          state_d  = ST_HIGH;
          hi_cnt_d = 5'd1;
        end else if (low_cnt_q == LATCH_M1) begin
          state_d   = ST_IDLE;
          low_cnt_d = '0;
          if (bit_cnt_q != 5'd0) begin
            bit_error_d = 1'b1;
            bit_cnt_d   = '0;
          end
          if (pix_cnt_q != 8'd0) begin
            frame_done_d  = 1'b1;
            pixel_count_d = pix_cnt_q;
            pix_cnt_d     = '0;
            pixel_index_d = '0;
          end
        end else if (low_cnt_q != 10'h3FF) begin
          low_cnt_d = low_cnt_q + 10'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clock_12mhz or posedge led_counter_reset) begin
    if (led_counter_reset) begin
      state_q       <= ST_SYNC;
      hi_cnt_q      <= '0;
      low_cnt_q     <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      pix_cnt_q     <= '0;
      pixel_data_q  <= '0;
      pixel_index_q <= '0;
      pixel_count_q <= '0;
      pixel_valid_q <= 1'b0;
      frame_done_q  <= 1'b0;
      bit_error_q   <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      hi_cnt_q      <= hi_cnt_d;
      low_cnt_q     <= low_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      pix_cnt_q     <= pix_cnt_d;
      pixel_data_q  <= pixel_data_d;
      pixel_index_q <= pixel_index_d;
      pixel_count_q <= pixel_count_d;
      pixel_valid_q <= pixel_valid_d;
      frame_done_q  <= frame_done_d;
      bit_error_q   <= bit_error_d;
      overflow_q    <= overflow_d;
    end
  end

  assign pixel_data  = pixel_data_q;
  assign pixel_valid = pixel_valid_q;
  assign pixel_index = pixel_index_q;
  assign frame_done  = frame_done_q;
  assign pixel_count = pixel_count_q;
  assign bit_error   = bit_error_q;
  assign overflow    = overflow_q;
endmodule

// File: tb/tb_led_stream_decoder.sv
// Bench for led_stream_decoder: drives WS2812-style waveforms and compares the
// decoded pixel/frame/error events against a frame-level reference model.
module tb_led_stream_decoder;
  import led_protocol_pkg::*;

  logic        clock_12mhz = 1'b0;
  logic        led_counter_reset = 1'b1;
  logic        din = 1'b0;
  logic [23:0] pixel_data;
  logic        pixel_valid;
  logic [7:0]  pixel_index;
  logic        frame_done;
  logic [7:0]  pixel_count;
  logic        bit_error;
  logic        overflow;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock_12mhz = ~clock_12mhz;

  led_stream_decoder dut (
    .clock_12mhz      (clock_12mhz),
    .led_counter_reset(led_counter_reset),
    .din              (din),
    .pixel_data       (pixel_data),
    .pixel_valid      (pixel_valid),
    .pixel_index      (pixel_index),
    .frame_done       (frame_done),
    .pixel_count      (pixel_count),
    .bit_error        (bit_error),
    .overflow         (overflow)
  );

  // Observed events, collected away from the active edge.
  logic [31:0] obs_pix[$];
  int          obs_fd[$];
  int          obs_err = 0;
  int          collide = 0;

  always @(negedge clock_12mhz) begin
    if (pixel_valid) obs_pix.push_back({pixel_index, pixel_data});
    if (frame_done) obs_fd.push_back(int'(pixel_count));
    if (bit_error) obs_err++;
    if (pixel_valid && frame_done) collide++;
  end

  // Reference model: line-level bookkeeping of what the decoder should report.
  logic [31:0] exp_pix[$];
  int          exp_fd[$];
  int          exp_err = 0;
  bit          exp_ovf = 0;
  bit          m_synced = 0;
  int          m_bits = 0;
  int          m_frame = 0;
  logic [23:0] m_shift = '0;

  task automatic check_value(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clock_12mhz);
  endtask

  task automatic drive(logic v, int n);
    din = v;
    tick(n);
  endtask

  task automatic send_bit(bit b, int hi, int lo);
    drive(1'b1, hi);
    drive(1'b0, lo);
    if (m_synced) begin
      m_shift = {m_shift[22:0], b};
      m_bits++;
      if (m_bits == 24) begin
        m_bits = 0;
        if (m_frame < int'(NUM_LEDS_DEF)) exp_pix.push_back({8'(m_frame), m_shift});
        else exp_ovf = 1'b1;
        m_frame++;
      end
    end
  endtask

  // mode 0: nominal 10/5 and 5/10; mode 1: fast; otherwise random legal widths.
  task automatic send_pixel(logic [23:0] px, int mode);
    for (int i = 23; i >= 0; i--) begin
      bit b;
      int hi, lo;
      b = px[i];
      case (mode)
        0: begin hi = b ? 10 : 5; lo = b ? 5 : 10; end
        1: begin hi = b ? 8 : 2; lo = 2; end
        default: begin
          hi = b ? int'($urandom_range(16, 8)) : int'($urandom_range(7, 2));
          lo = int'($urandom_range(12, 1));
        end
      endcase
      send_bit(b, hi, lo);
    end
  endtask

  task automatic send_bits(int n);
    for (int i = 0; i < n; i++) send_bit(1'($urandom_range(1, 0)), 10, 5);
  endtask

  task automatic bad_high(int width);
    drive(1'b1, width);
    drive(1'b0, 5);
    if (m_synced) begin
      exp_err++;
      m_synced = 0;
      m_bits = 0;
      m_frame = 0;
    end
  endtask

  task automatic latch();
    drive(1'b0, int'(T_LATCH_DEF) + 12);
    if (m_synced) begin
      if (m_bits != 0) exp_err++;
      if (m_frame > 0) exp_fd.push_back(m_frame > int'(NUM_LEDS_DEF) ? int'(NUM_LEDS_DEF) : m_frame);
    end
    m_synced = 1;
    m_bits = 0;
    m_frame = 0;
  endtask

  task automatic do_reset();
    din = 1'b0;
    led_counter_reset = 1'b1;
    tick(3);
    led_counter_reset = 1'b0;
    m_synced = 0;
    m_bits = 0;
    m_frame = 0;
    exp_ovf = 1'b0;
  endtask

  task automatic compare_scenario(string tag);
    tick(4);
    check_value({tag, "_pix_n"}, obs_pix.size(), exp_pix.size());
    for (int i = 0; i < exp_pix.size() && i < obs_pix.size(); i++)
      check_value({tag, "_pix"}, obs_pix[i], exp_pix[i]);
    check_value({tag, "_fd_n"}, obs_fd.size(), exp_fd.size());
    for (int i = 0; i < exp_fd.size() && i < obs_fd.size(); i++)
      check_value({tag, "_cnt"}, obs_fd[i], exp_fd[i]);
    check_value({tag, "_err"}, obs_err, exp_err);
    check_value({tag, "_excl"}, collide, 0);
    check_value({tag, "_ovf"}, {31'd0, overflow}, {31'd0, exp_ovf});
    obs_pix.delete(); exp_pix.delete();
    obs_fd.delete();  exp_fd.delete();
    obs_err = 0; exp_err = 0;
  endtask

  initial begin
    int err_at;
    do_reset();
    tick(1);
    check_value("rst_data", pixel_data, 0);
    check_value("rst_index", pixel_index, 0);
    check_value("rst_count", pixel_count, 0);
    check_value("rst_pulses", {pixel_valid, frame_done, bit_error}, 0);
    check_value("rst_ovf", overflow, 0);

    // Traffic before the first latch gap is ignored.
    send_pixel(24'h123456, 0);
    send_pixel(24'hABCDEF, 0);
    latch();
    compare_scenario("pre_latch");

    send_pixel(24'hFF0000, 0);
    latch();
    compare_scenario("single");
    check_value("hold_data", pixel_data, 24'hFF0000);

    // Width boundaries 2,7 -> 0 and 8,16 -> 1.
    for (int i = 0; i < 6; i++) begin
      send_bit(1'b0, 2, 3);
      send_bit(1'b0, 7, 3);
      send_bit(1'b1, 8, 3);
      send_bit(1'b1, 16, 3);
    end
    latch();
    compare_scenario("bounds");

    for (int f = 0; f < 3; f++) begin
      int n;
      n = int'($urandom_range(4, 1));
      for (int p = 0; p < n; p++) send_pixel(24'($urandom), 2);
      latch();
    end
    compare_scenario("random");

    send_bits(12);
    latch();
    compare_scenario("partial");

    // Over-long high: error expected on the 17th synchronized high clock.
    send_bits(12);
    err_at = 0;
    din = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      if (bit_error && err_at == 0) err_at = i;
    end
    check_value("err_at", err_at, 19);
    din = 1'b0;
    bad_high(0);
    send_pixel(24'h0F0F0F, 0);
    latch();
    send_pixel(24'h5A5AA5, 2);
    latch();
    compare_scenario("long_high");

    send_bits(5);
    bad_high(1);
    send_pixel(24'h777777, 0);
    latch();
    send_pixel(24'h00FF00, 0);
    latch();
    compare_scenario("runt");

    // Reset in the middle of the 13th bit.
    send_bits(12);
    drive(1'b1, 4);
    do_reset();
    tick(1);
    check_value("mid_rst_data", pixel_data, 0);
    latch();
    send_pixel(24'($urandom), 0);
    latch();
    compare_scenario("reset_mid");

    for (int p = 0; p < 150; p++) send_pixel(p[0] ? 24'h55AA00 : 24'h00AA55, 1);
    latch();
    compare_scenario("full");

    for (int p = 0; p < 151; p++) send_pixel(p[0] ? 24'h55AA00 : 24'h00AA55, 1);
    latch();
    compare_scenario("over");

    do_reset();
    tick(1);
    check_value("ovf_clear", overflow, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
